// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch, load/store) in front of
// a single-port synchronous memory with 1-cycle read latency.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous unlocked requests alternate via a last-winner register
//   undefined -> simultaneous requests go to load/store; fetch escapes only via
//                the starvation override
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request / byte address
//   if_gnt, if_rvalid, if_rdata   fetch grant, response valid, read data
//   ls_req, ls_we, ls_be,         load/store request, write enable, byte enables,
//   ls_addr, ls_wdata, ls_lock    byte address, write data, bus lock
//   ls_gnt, ls_rvalid, ls_rdata   load/store grant, response valid, read data
//   mem_en, mem_we, mem_addr,     memory enable, byte write enables, word-aligned
//   mem_wdata, mem_rdata          address, write data, read data (1-cycle latency)
//
// Response state (resp)
//   state     | meaning
//   RESP_NONE | no access accepted last cycle, no rvalid
//   RESP_IF   | fetch accepted last cycle, if_rvalid this cycle
//   RESP_LS   | load/store accepted last cycle, ls_rvalid this cycle

module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    input  logic              ls_lock,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_LS   = 2'd2
    } resp_t;

    resp_t            resp, resp_nxt;
    logic             locked, locked_nxt;
    logic [CNT_W-1:0] starve, starve_nxt;
    logic             starved;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls, last_ls_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_ls <= 1'b1;
        else     last_ls <= last_ls_nxt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp   <= RESP_NONE;
            locked <= 1'b0;
            starve <= '0;
        end else begin
            resp   <= resp_nxt;
            locked <= locked_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_nxt   = RESP_NONE;
        locked_nxt = locked;
        starve_nxt = starve;
`ifdef ARB_ROUND_ROBIN_EN
        last_ls_nxt = last_ls;
`endif
        starved = if_req && (starve == CNT_MAX);

        // Grants are forced low while reset is held so the memory sees no access.
        if (!rst) begin
            if (locked) begin
                ls_gnt = ls_req;
            end else if (starved) begin
                if_gnt = 1'b1;
            end else if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_ls) if_gnt = 1'b1;
                else         ls_gnt = 1'b1;
`else
                ls_gnt = 1'b1;
`endif
            end else begin
                if_gnt = if_req;
                ls_gnt = ls_req;
            end
        end

        if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr & WORD_MASK;
            mem_wdata = ls_wdata;
            resp_nxt  = RESP_IF;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_nxt = 1'b0;
`endif
        end else if (ls_gnt) begin
            mem_en     = 1'b1;
            mem_addr   = ls_addr & WORD_MASK;
            mem_we     = ls_we ? ls_be : 4'b0000;
            mem_wdata  = ls_wdata;
            resp_nxt   = RESP_LS;
            locked_nxt = ls_lock;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls_nxt = 1'b1;
`endif
        end

        // Saturating count of consecutive cycles fetch waited while requesting.
        if (!if_req || if_gnt) starve_nxt = '0;
        else if (starve != CNT_MAX) starve_nxt = starve + CNT_W'(1);
    end

    assign if_rvalid = (resp == RESP_IF);
    assign ls_rvalid = (resp == RESP_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level model
// (who wins this cycle, who owes a response next cycle) is checked against the DUT
// every cycle, plus directed checks with literal expected values.

module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int SMAX   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [31:0]       if_rdata;
    logic              ls_req = 1'b0, ls_we = 1'b0, ls_lock = 1'b0;
    logic [3:0]        ls_be = 4'h0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [31:0]       ls_wdata = '0;
    logic              ls_gnt, ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_lock(ls_lock),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model state: 0 = nobody, 1 = fetch, 2 = load/store
    int m_owner   = 0;   // owes a response this cycle
    int m_starve  = 0;
    int m_last    = 2;
    bit m_locked  = 0;

    function automatic int winner();
        if (rst) return 0;
        if (m_locked) return ls_req ? 2 : 0;
        if (if_req && m_starve == SMAX) return 1;
        if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (if_req) return 1;
        if (ls_req) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        int          w;
        int          own;
        logic [31:0] ea, ewd;
        logic [3:0]  ewe;
        w   = winner();
        own = rst ? 0 : m_owner;
        ea  = (w == 1) ? (if_addr & ~32'h3) : (w == 2) ? (ls_addr & ~32'h3) : 32'h0;
        ewe = (w == 2 && ls_we) ? ls_be : 4'h0;
        ewd = (w != 0) ? ls_wdata : 32'h0;
        chk("m_if_gnt",    32'(if_gnt),    32'(w == 1));
        chk("m_ls_gnt",    32'(ls_gnt),    32'(w == 2));
        chk("m_mem_en",    32'(mem_en),    32'(w != 0));
        chk("m_mem_addr",  mem_addr,       ea);
        chk("m_mem_we",    32'(mem_we),    32'(ewe));
        chk("m_mem_wdata", mem_wdata,      ewd);
        chk("m_if_rvalid", 32'(if_rvalid), 32'(own == 1));
        chk("m_ls_rvalid", 32'(ls_rvalid), 32'(own == 2));
        chk("m_if_rdata",  if_rdata,       (own == 1) ? mem_rdata : 32'h0);
        chk("m_ls_rdata",  ls_rdata,       (own == 2) ? mem_rdata : 32'h0);
        // advance to the state the next rising edge produces
        if (rst) begin
            m_owner = 0; m_starve = 0; m_last = 2; m_locked = 0;
        end else begin
            m_owner = w;
            if (w != 0) m_last = w;
            if (w == 2) m_locked = ls_lock;
            if (!if_req || w == 1) m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
        end
    end

    task automatic idle();
        if_req = 0; ls_req = 0; ls_we = 0; ls_be = 4'h0; ls_lock = 0;
    endtask

    task automatic next();
        @(posedge clk); #1;
        mem_rdata = $urandom;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnts"},   32'({if_gnt, ls_gnt}), 32'h0);
        chk({tag, "_rvalid"}, 32'({if_rvalid, ls_rvalid}), 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_rdata"},  if_rdata | ls_rdata, 32'h0);
    endtask

    string seq;

    initial begin
        // reset state, with requests present to show grants are held off
        if_req = 1; ls_req = 1; ls_addr = 32'h40; if_addr = 32'h80;
        look();
        chk_all_zero("reset");
        next(); idle(); rst = 0;
        look();

        // fetch only
        next(); if_req = 1; if_addr = 32'h0000_0104;
        look();
        chk("f_if_gnt", 32'(if_gnt), 32'h1);
        chk("f_mem_addr", mem_addr, 32'h0000_0104);
        chk("f_mem_we", 32'(mem_we), 32'h0);
        next(); idle();
        look();
        chk("f_if_rvalid", 32'(if_rvalid), 32'h1);
        chk("f_if_rdata", if_rdata, mem_rdata);
        chk("f_ls_rdata", ls_rdata, 32'h0);

        // store with sub-word address
        next(); ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h0000_0206;
        ls_wdata = 32'hDEAD_BEEF;
        look();
        chk("s_ls_gnt", 32'(ls_gnt), 32'h1);
        chk("s_mem_addr", mem_addr, 32'h0000_0204);
        chk("s_mem_we", 32'(mem_we), 32'h3);
        chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next(); idle();
        look();
        chk("s_ls_rvalid", 32'(ls_rvalid), 32'h1);
        chk("s_if_rvalid", 32'(if_rvalid), 32'h0);

        // both requesting continuously
`ifdef ARB_ROUND_ROBIN_EN
        seq = "ILILIL";
`else
        seq = "LLLLIL";
`endif
        for (int i = 0; i < 6; i++) begin
            next(); if_req = 1; if_addr = 32'h1000 + 32'(4 * i);
            ls_req = 1; ls_we = 0; ls_addr = 32'h2000 + 32'(4 * i);
            look();
            chk($sformatf("both_if_gnt_%0d", i), 32'(if_gnt), 32'(seq[i] == "I"));
            chk($sformatf("both_ls_gnt_%0d", i), 32'(ls_gnt), 32'(seq[i] == "L"));
        end
        next(); idle();
        look();

        // locked stores, counter saturates at STARVE_MAX behind the lock
        for (int i = 0; i < 8; i++) begin
            next(); if_req = 1; if_addr = 32'h3000;
            ls_req = 1; ls_we = 1; ls_be = 4'hF; ls_addr = 32'h4000 + 32'(4 * i);
            ls_wdata = 32'hA500_0000 + 32'(i); ls_lock = (i < 6);
            look();
`ifndef ARB_ROUND_ROBIN_EN
            chk($sformatf("lock_if_gnt_%0d", i), 32'(if_gnt), 32'(i == 7));
            chk($sformatf("lock_ls_gnt_%0d", i), 32'(ls_gnt), 32'(i != 7));
`endif
        end
        next(); idle();
        look();

        // reset pulsed the cycle after a load acceptance
        next(); ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0300;
        look();
        chk("r_ls_gnt", 32'(ls_gnt), 32'h1);
        next(); rst = 1; if_req = 1;
        look();
        chk_all_zero("rst_mid");
        next(); rst = 0; idle();
        look();
        chk("r_ls_rvalid_0", 32'(ls_rvalid), 32'h0);
        next();
        look();
        chk("r_ls_rvalid_1", 32'(ls_rvalid), 32'h0);

        // mixed traffic, checked by the model only
        for (int i = 0; i < 60; i++) begin
            next();
            if_req = 1'($urandom); if_addr = $urandom;
            ls_req = 1'($urandom); ls_we = 1'($urandom); ls_be = 4'($urandom);
            ls_addr = $urandom; ls_wdata = $urandom;
            ls_lock = ($urandom_range(0, 3) == 0);
            look();
        end
        next(); idle();
        look();
        look();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
